// File: rtl/multicycle_mem_pkg.sv
// Shared types and constants for the multi-cycle data memory.
// The FSM state enum and the line-offset helpers live here.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_LAT       = 4;
    localparam int DEF_BURST_LEN = 8;
    localparam int CNT_W         = 4;
    localparam int OFS_W         = $clog2(DEF_BURST_LEN) + 1;

    // Number of low byte-address bits cleared to line-align a burst.
    function automatic int ofs_width(input int burst_len);
        return $clog2(burst_len) + 1;
    endfunction

endpackage

// File: rtl/multicycle_mem_if.sv
// Request/response bundle between the memory-stage client and multicycle_mem.
// Protocol: the client pulses req_en only while busy=0; req_en during busy=1 is
// dropped. The responder drives one beat per cycle with rsp_valid=1 and the
// client must take it that cycle (no back-pressure); rsp_last marks the final beat.
interface multicycle_mem_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          req_en;
    logic          req_wr;
    logic          req_burst;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          busy;
    logic          rsp_valid;
    logic          rsp_last;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;

    modport master (
        output req_en, req_wr, req_burst, req_addr, req_wdata,
        input  busy, rsp_valid, rsp_last, rsp_addr, rsp_data
    );

    modport slave (
        input  req_en, req_wr, req_burst, req_addr, req_wdata,
        output busy, rsp_valid, rsp_last, rsp_addr, rsp_data
    );
endinterface

// File: rtl/multicycle_mem_word_array.sv
// Single-port word storage: synchronous write, combinational read.
// Contents are intentionally not reset.
module mem_word_array #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-2:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**(AW-1)];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/multicycle_mem.sv
// Multi-cycle data memory responder: one single read/write or one line burst
// read at a time, answered LAT cycles after acceptance with registered beats.
module multicycle_mem
    import mem_pkg::*;
#(
    parameter int DW        = 16,
    parameter int AW        = 16,
    parameter int LAT       = DEF_LAT,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic           clk,
    input  logic           rst_n,
    multicycle_mem_if.slave bus,
    output state_t         dbg_state_o
);

    localparam int                BW        = $clog2(BURST_LEN);
    localparam int                OFS_L     = ofs_width(BURST_LEN);
    localparam logic [AW-1:0]     LINE_MASK = AW'((1 << OFS_L) - 1);
    localparam logic [CNT_W-1:0]  LAT_LOAD  = CNT_W'(LAT - 1);
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BURST_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic             wr_q, wr_d;
    logic             burst_q, burst_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             busy_q, busy_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_last_q, rsp_last_d;
    logic [AW-1:0]    rsp_addr_q, rsp_addr_d;
    logic [DW-1:0]    rsp_data_q, rsp_data_d;

    logic [AW-1:0]    beat_addr;
    logic [DW-1:0]    mem_rdata;
    logic             mem_we;

    // Burst base is line-aligned, so adding the beat offset never leaves the line.
    assign beat_addr = burst_q ? addr_q + AW'({beat_q, 1'b0}) : addr_q;

    mem_word_array #(
        .AW (AW),
        .DW (DW)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (beat_addr[AW-1:1]),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        beat_d      = beat_q;
        wr_d        = wr_q;
        burst_d     = burst_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        mem_we      = 1'b0;

        // busy drops at the edge that ends the final beat.
        if (rsp_last_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.req_en && !busy_q) begin
                    wr_d    = bus.req_wr;
                    burst_d = bus.req_burst && !bus.req_wr;
                    wdata_d = bus.req_wdata;
                    addr_d  = (bus.req_burst && !bus.req_wr)
                              ? (bus.req_addr & ~LINE_MASK)
                              : {bus.req_addr[AW-1:1], 1'b0};
                    busy_d  = 1'b1;
                    lat_d   = LAT_LOAD;
                    beat_d  = '0;
                    state_d = (LAT == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                lat_d = lat_q - 1'b1;
                if (lat_q <= CNT_W'(1)) begin
                    beat_d  = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_addr_d  = beat_addr;
                rsp_data_d  = wr_q ? wdata_q : mem_rdata;
                mem_we      = wr_q;
                if (!burst_q || beat_q == LAST_BEAT) begin
                    rsp_last_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            beat_q      <= '0;
            wr_q        <= 1'b0;
            burst_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            beat_q      <= beat_d;
            wr_q        <= wr_d;
            burst_q     <= burst_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_last  = rsp_last_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_data  = rsp_data_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_multicycle_mem.sv
// Bench for multicycle_mem: LAT=4 instance driven through a scoreboard,
// plus a LAT=1 instance for back-to-back acceptance spacing.
module tb_multicycle_mem;
    import mem_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int EW = 1 + AW + DW;

    logic clk;
    logic rst_n;
    state_t dbg_state;
    state_t dbg_state1;

    int n_checks = 0;
    int n_errors = 0;
    int beats_seen = 0;

    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] model_mem [logic [AW-2:0]];

    multicycle_mem_if #(.AW(AW), .DW(DW)) bus ();
    multicycle_mem_if #(.AW(AW), .DW(DW)) bus1 ();

    multicycle_mem #(.DW(DW), .AW(AW), .LAT(4), .BURST_LEN(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    multicycle_mem #(.DW(DW), .AW(AW), .LAT(1), .BURST_LEN(8)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus1),
        .dbg_state_o (dbg_state1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-2:0] w);
        if (model_mem.exists(w)) return model_mem[w];
        return '0;
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (bus.rsp_valid) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                check("extra_beat", 1, 0);
            end else begin
                check("rsp_beat", {bus.rsp_last, bus.rsp_addr, bus.rsp_data}, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic send_req(input logic wr, input logic burst, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data);
        int n = 0;
        logic [AW-1:0] base;
        @(negedge clk);
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_wait_idle", bus.busy, 0);
        bus.req_en    = 1'b1;
        bus.req_wr    = wr;
        bus.req_burst = burst;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        if (wr) begin
            model_mem[addr[AW-1:1]] = data;
            exp_q.push_back({1'b1, addr & 16'hFFFE, data});
        end else if (burst) begin
            base = addr & 16'hFFF0;
            for (int b = 0; b < 8; b++) begin
                exp_q.push_back({(b == 7), base + AW'(2 * b), model_rd(base[AW-1:1] + 15'(b))});
            end
        end else begin
            exp_q.push_back({1'b1, addr & 16'hFFFE, model_rd(addr[AW-1:1])});
        end
        @(posedge clk);
        #1;
        bus.req_en = 1'b0;
        bus.req_wr = 1'b0;
        bus.req_burst = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || bus.busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic timed_read(input logic [AW-1:0] addr);
        send_req(1'b0, 1'b0, addr, '0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check($sformatf("t_busy_c%0d", i), bus.busy, (i <= 5));
            check($sformatf("t_valid_c%0d", i), bus.rsp_valid, (i == 5));
            check($sformatf("t_last_c%0d", i), bus.rsp_last, (i == 5));
        end
    endtask

    task automatic d1_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int n = 0;
        @(negedge clk);
        while (bus1.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus1.req_en    = 1'b1;
        bus1.req_wr    = 1'b1;
        bus1.req_addr  = addr;
        bus1.req_wdata = data;
        @(posedge clk);
        #1;
        bus1.req_en = 1'b0;
        bus1.req_wr = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus1.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("d1_wr_echo", {bus1.rsp_last, bus1.rsp_addr, bus1.rsp_data}, {1'b1, addr, data});
    endtask

    initial begin
        int n;
        int start;
        rst_n = 1'b0;
        bus.req_en = 1'b0;  bus.req_wr = 1'b0;  bus.req_burst = 1'b0;
        bus.req_addr = '0;  bus.req_wdata = '0;
        bus1.req_en = 1'b0; bus1.req_wr = 1'b0; bus1.req_burst = 1'b0;
        bus1.req_addr = '0; bus1.req_wdata = '0;
        #3;
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.rsp_valid, 0);
        check("rst_last", bus.rsp_last, 0);
        check("rst_addr", bus.rsp_addr, 0);
        check("rst_data", bus.rsp_data, 0);
        check("rst_state", dbg_state, IDLE);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // single read latency with LAT=4
        send_req(1'b1, 1'b0, 16'h0010, 16'hBEEF);
        wait_drain();
        timed_read(16'h0010);

        // write then read back as soon as idle
        send_req(1'b1, 1'b0, 16'h0042, 16'h1234);
        send_req(1'b0, 1'b0, 16'h0042, '0);
        wait_drain();

        // burst read over a line holding word index values
        for (int i = 0; i < 8; i++) begin
            send_req(1'b1, 1'b0, 16'h0020 + AW'(2 * i), 16'h0010 + DW'(i));
        end
        wait_drain();
        send_req(1'b0, 1'b1, 16'h002A, '0);
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int b = 0; b < 8; b++) begin
            check($sformatf("burst_valid_b%0d", b), bus.rsp_valid, 1);
            check($sformatf("burst_last_b%0d", b), bus.rsp_last, (b == 7));
            if (b < 7) @(negedge clk);
        end
        @(negedge clk);
        check("burst_after_valid", bus.rsp_valid, 0);
        check("burst_after_busy", bus.busy, 0);
        wait_drain();

        // write pulsed while busy must be ignored
        send_req(1'b1, 1'b0, 16'h0000, 16'h5A5A);
        wait_drain();
        start = beats_seen;
        send_req(1'b0, 1'b0, 16'h0000, '0);
        @(negedge clk);
        check("busy_at_ignored", bus.busy, 1);
        bus.req_en = 1'b1; bus.req_wr = 1'b1;
        bus.req_addr = 16'h0000; bus.req_wdata = 16'hFFFF;
        @(posedge clk);
        #1;
        bus.req_en = 1'b0; bus.req_wr = 1'b0;
        wait_drain();
        send_req(1'b0, 1'b0, 16'h0000, '0);
        wait_drain();
        repeat (4) @(negedge clk);
        check("ignored_beats", beats_seen - start, 2);

        // reset in the middle of burst beat 3
        start = beats_seen;
        send_req(1'b0, 1'b1, 16'h0020, '0);
        n = 0;
        while (beats_seen < start + 3 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.rsp_valid, 0);
        check("mid_rst_last", bus.rsp_last, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_state", dbg_state, IDLE);
        check("mid_rst_discard", exp_q.size(), 5);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        timed_read(16'h0042);
        wait_drain();

        // LAT=1 instance: req_en held high, second accept lands 3 cycles later
        d1_write(16'h0004, 16'hA5A5);
        d1_write(16'h0006, 16'h3C3C);
        n = 0;
        @(negedge clk);
        while (bus1.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus1.req_en = 1'b1; bus1.req_wr = 1'b0; bus1.req_addr = 16'h0004;
        @(posedge clk);
        #1;
        bus1.req_addr = 16'h0006;
        @(negedge clk);
        check("l1_c1_busy", bus1.busy, 1);
        check("l1_c1_valid", bus1.rsp_valid, 0);
        @(negedge clk);
        check("l1_beat_a", {bus1.rsp_valid, bus1.rsp_last, bus1.rsp_addr, bus1.rsp_data},
              {1'b1, 1'b1, 16'h0004, 16'hA5A5});
        @(negedge clk);
        check("l1_c3_busy", bus1.busy, 0);
        check("l1_c3_valid", bus1.rsp_valid, 0);
        @(negedge clk);
        check("l1_c4_busy", bus1.busy, 1);
        check("l1_c4_valid", bus1.rsp_valid, 0);
        bus1.req_en = 1'b0;
        @(negedge clk);
        check("l1_beat_b", {bus1.rsp_valid, bus1.rsp_last, bus1.rsp_addr, bus1.rsp_data},
              {1'b1, 1'b1, 16'h0006, 16'h3C3C});
        @(negedge clk);
        check("l1_c6_busy", bus1.busy, 0);
        check("l1_c6_valid", bus1.rsp_valid, 0);

        repeat (5) @(negedge clk);
        check("final_queue", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
